// File: rtl/reg_files.sv
// reg_files: 32 x 32-bit register file, two async read ports, one sync write port, r0 hardwired to 0.
// Optional macro RF_WB_BYPASS_EN forwards wb_data to a read port whose index matches rwd.
module reg_files #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [2*ADDR_W-1:0] rs_rt,
    input  logic [ADDR_W-1:0]   rwd,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [DATA_W-1:0]   val_rs,
    output logic [DATA_W-1:0]   val_rt
);
    localparam int DEPTH = 2**ADDR_W;
    logic [DATA_W-1:0] regs [1:DEPTH-1];
    logic [ADDR_W-1:0] rs, rt;
    assign rs = rs_rt[2*ADDR_W-1:ADDR_W];
    assign rt = rs_rt[ADDR_W-1:0];
    always_ff @(posedge CLK)
        if (RST)
            for (int i = 1; i < DEPTH; i++) regs[i] <= '0;
        else if (rwd != '0)
            regs[rwd] <= wb_data;
`ifdef RF_WB_BYPASS_EN
    logic fwd_rs, fwd_rt;
    assign fwd_rs = !RST && rwd != '0 && rwd == rs;
    assign fwd_rt = !RST && rwd != '0 && rwd == rt;
    assign val_rs = (rs == '0) ? '0 : fwd_rs ? wb_data : regs[rs];
    assign val_rt = (rt == '0) ? '0 : fwd_rt ? wb_data : regs[rt];
`else
    assign val_rs = (rs == '0) ? '0 : regs[rs];
    assign val_rt = (rt == '0) ? '0 : regs[rt];
`endif
endmodule

// File: tb/tb_reg_files.sv
// tb_reg_files: directed plus randomized checks of reg_files against an array-based reference model.
module tb_reg_files;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [9:0]  rs_rt = '0;
    logic [4:0]  rwd = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] val_rs, val_rt;
    logic [31:0] model [0:31];
    int n_chk = 0;
    int n_pass = 0;

    reg_files dut (
        .CLK(CLK), .RST(RST), .rs_rt(rs_rt), .rwd(rwd),
        .wb_data(wb_data), .val_rs(val_rs), .val_rt(val_rt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] expect_rd(input logic [4:0] idx, input logic pre_edge);
        if (idx == 0) return 32'h0;
`ifdef RF_WB_BYPASS_EN
        if (pre_edge && !RST && rwd != 0 && rwd == idx) return wb_data;
`endif
        return model[idx];
    endfunction

    task automatic check_reads(input string tag, input logic pre_edge);
        chk({tag, "_rs"}, val_rs, expect_rd(rs_rt[9:5], pre_edge));
        chk({tag, "_rt"}, val_rt, expect_rd(rs_rt[4:0], pre_edge));
    endtask

    // One full cycle: drive after negedge, check before and after the rising edge.
    task automatic cycle(input string tag, input logic r, input logic [4:0] d,
                         input logic [31:0] w, input logic [4:0] a, input logic [4:0] b);
        @(negedge CLK);
        RST = r; rwd = d; wb_data = w; rs_rt = {a, b};
        #1 check_reads({tag, "_pre"}, 1'b1);
        @(posedge CLK);
        if (r) for (int i = 0; i < 32; i++) model[i] = 32'h0;
        else if (d != 0) model[d] = w;
        #1 check_reads({tag, "_post"}, 1'b0);
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [4:0] b);
        @(negedge CLK);
        RST = 1'b0; rwd = 5'd0; rs_rt = {a, b};
        #1 check_reads(tag, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        cycle("reset", 1'b1, 5'd0, 32'h0, 5'd0, 5'd0);
        @(negedge CLK);
        RST = 1'b0; rwd = 5'd0;
        for (int i = 0; i < 1024; i++) begin
            rs_rt = i[9:0];
            #0.5;
            chk("sweep_rs", val_rs, 32'h0);
            chk("sweep_rt", val_rt, 32'h0);
        end
        for (int i = 1; i < 32; i++)
            cycle("wr_pat", 1'b0, i[4:0], 32'hA5A5_0000 + i, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            logic [4:0] a, b;
            a = i[4:0]; b = 5'd31 - a;
            peek("rd_pat", a, b);
            if (i != 0) chk("rd_pat_const", val_rs, 32'hA5A5_0000 + i);
        end
        cycle("r0_write", 1'b0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd1);
        for (int i = 0; i < 32; i++) peek("after_r0", i[4:0], 5'd0);
        cycle("set5", 1'b0, 5'd5, 32'h1234_5678, 5'd5, 5'd5);
        cycle("rdw5", 1'b0, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
        chk("rdw5_const", val_rs, 32'hDEAD_BEEF);
        cycle("set7", 1'b0, 5'd7, 32'h0000_0099, 5'd7, 5'd0);
        cycle("rst_vs_wr", 1'b1, 5'd7, 32'h0000_0042, 5'd7, 5'd7);
        chk("rst_vs_wr_const", val_rs, 32'h0);
        cycle("b2b_1", 1'b0, 5'd3, 32'h1, 5'd3, 5'd0);
        cycle("b2b_2", 1'b0, 5'd3, 32'h2, 5'd3, 5'd3);
        peek("b2b_rd", 5'd3, 5'd3);
        chk("b2b_const", val_rt, 32'h2);
        for (int n = 0; n < 600; n++) begin
            logic r;
            logic [4:0] d;
            r = ($urandom_range(0, 49) == 0);
            d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            cycle("rand", r, d, $urandom, 5'($urandom),
                  ($urandom_range(0, 3) == 0) ? d : 5'($urandom));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
